// File: rtl/bcd_down_timer_if.sv
//------------------------------------------------------------------------------
// bcd_down_timer_if : control/data bundle of the cascaded BCD down-timer
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bcd_down_timer_if #(
  parameter int DIGITS = 4
);
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic                  ce;
  logic                  reload;
  logic [4*DIGITS-1:0]   count;
  logic                  zero;
  logic                  ceo;
  logic                  done;
  logic                  error;

  modport master (
    output clear, load, data, ce, reload,
    input  count, zero, ceo, done, error
  );

  modport slave (
    input  clear, load, data, ce, reload,
    output count, zero, ceo, done, error
  );
endinterface

`default_nettype wire

// File: rtl/bcd_down_timer.sv
//------------------------------------------------------------------------------
// bcd_down_timer : cascaded BCD down-counter with load check, done pulse and
// optional auto-reload (enabled by macro BCD_TIMER_RELOAD_EN)
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_down_timer #(
  parameter int DIGITS   = 4,
  parameter int SEC_MODE = 1
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  bcd_down_timer_if.slave bus
);

  localparam int W            = 4 * DIGITS;
  localparam bit C_SEC_ACTIVE = (SEC_MODE == 1) && (DIGITS >= 2);

  logic [W-1:0]      r_count;
  logic              r_done;
  logic              r_error;

  logic [W-1:0]      w_dec;
  logic [DIGITS-1:0] w_borrow;
  logic [DIGITS-1:0] w_bad;
  logic              w_zero;
  logic              w_load_ok;

  // Per-digit borrow chain, wrap-to-max and load range check.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    localparam logic [3:0] C_MAX = (C_SEC_ACTIVE && i == 1) ? 4'd5 : 4'd9;
    logic [3:0] w_digit;
    assign w_digit = r_count[4*i +: 4];

    if (i == 0) begin : g_first
      assign w_borrow[i] = 1'b1;
    end else begin : g_rest
      assign w_borrow[i] = w_borrow[i-1] & (r_count[4*(i-1) +: 4] == 4'd0);
    end

    assign w_dec[4*i +: 4] = !w_borrow[i]      ? w_digit :
                             (w_digit == 4'd0) ? C_MAX   :
                                                 w_digit - 4'd1;
    assign w_bad[i] = (bus.data[4*i +: 4] > C_MAX);
  end

  assign w_zero    = (r_count == '0);
  assign w_load_ok = ~|w_bad;

`ifdef BCD_TIMER_RELOAD_EN
  logic [W-1:0] r_preset;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_preset <= '0;
    end else if (!bus.clear && bus.load && w_load_ok) begin
      r_preset <= bus.data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.clear) begin
        r_count <= '0;
        r_error <= 1'b0;
      end else if (bus.load) begin
        if (w_load_ok) begin
          r_count <= bus.data;
          r_error <= 1'b0;
        end else begin
          r_count <= '0;
          r_error <= 1'b1;
        end
      end else if (bus.ce) begin
        if (!w_zero) begin
          r_count <= w_dec;
          r_done  <= (w_dec == '0);
        end
`ifdef BCD_TIMER_RELOAD_EN
        // Reload from zero never pulses done; a zero preset simply holds.
        else if (bus.reload) begin
          r_count <= r_preset;
        end
`endif
      end
    end
  end

  assign bus.count = r_count;
  assign bus.done  = r_done;
  assign bus.error = r_error;
  assign bus.zero  = w_zero;
  assign bus.ceo   = bus.ce & w_zero;

endmodule

`default_nettype wire
